period_tx: RTL and testbench
============================

# period_tx

Frontend serializer for the coarse time base: each time the frontend timer rolls over (`period_done`), this block captures the 48-bit `period` count and shifts it out as a framed, integrity-checked serial word on a single line toward the backend. It sits beside the frontend timer and drives the time-sync path to the backend. There it is the transmitting end of the period-tag link, and the backend deframer is the receiving end.

## Interface
Parameters:
- `PERIOD_W`, 48, width of the period count carried per frame
- `DIV`, 1, clocks per serial bit (≥1)
- `SYNC_WORD`, 8'hB5, frame sync pattern sent MSB first

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  when low, new `period_done` pulses are ignored; a frame already in progress completes
- `period_done`  in  1  one-clock rollover strobe from the frontend timer
- `period`  in  `PERIOD_W`  period count; sampled in the cycle `period_done` is high
- `tx`  out  1  serial line; idles low
- `busy`  out  1  high while a frame is being sent
- `overrun`  out  1  sticky; set when a strobe is dropped because a frame is in progress
- `frames`  out  16  count of completed frames, wrapping at 16'hFFFF→0

## Operation
- Reset values: `tx`=0, `busy`=0, `overrun`=0, `frames`=0, FSM in IDLE, bit divider=0.
- Frame, MSB first: start bit (1), `SYNC_WORD` (8), `period` (`PERIOD_W`), check field, stop bit (0).
- Check field without the macro: one even-parity bit, equal to the XOR of the `PERIOD_W` data bits only.
- FSM states: IDLE → START → SYNC → DATA → CHECK → STOP → IDLE.
- IDLE→START: on `period_done` & `en`. `period` is latched in the same edge.
- In each state, the state's bit is held for `DIV` clocks. The bit index advances when the divider reaches `DIV-1`.
- STOP→IDLE: at the end of the stop bit. `frames` increments in the same edge.
- `period_done` while not in IDLE:
  - the strobe is ignored;
  - the latched value is unchanged;
  - `overrun` is set on the next edge.
  - `overrun` is cleared only by `rst`.
- A `period_done` in the final stop-bit cycle is treated as busy, so it is an overrun.
- `period_done` with `en`=0 in IDLE: ignored, no overrun.
- Reset asserted mid-frame: all outputs return to reset values immediately. There is no partial-frame completion.

## Timing
- Strobe at edge T is accepted. The start bit appears on `tx` from T+1, and `busy` rises at T+1.
- Frame length is `FRAME_BITS` = 1+8+`PERIOD_W`+CHECK_W+1, which is 59 by default.
- `busy` falls, and `frames` increments, at T+1+`FRAME_BITS`·`DIV`.
- For back-to-back operation, the timer period must be > `FRAME_BITS`·`DIV` clocks. This holds for COUNTER≥7 at `DIV`=1.

## Configuration
- `PERIOD_TX_CRC8_EN` defined:
  - The check field is a CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over the `PERIOD_W` data bits, sent MSB first.
  - CHECK_W=8 and `FRAME_BITS`=66.
- `PERIOD_TX_CRC8_EN` undefined: the check field is the single parity bit, CHECK_W=1.

## Structure
- Package `period_tx_pkg`:
  - FSM state enum;
  - CHECK_W and `FRAME_BITS` localparam functions of `PERIOD_W`;
  - CRC-8 polynomial constant.
- Sub-module `crc8_serial`:
  - bit-serial CRC-8 with clear, bit-enable and data-bit inputs, plus an 8-bit remainder output;
  - instantiated only under `PERIOD_TX_CRC8_EN`.

## Test plan
- Default parameters, `period`=48'h0000_0000_0001 strobed once:
  - `tx` from T+1 is 1, then 10110101, then 47 zeros and a 1, then parity 1, then stop 0;
  - `busy` falls at T+60 and `frames`=1.
- `DIV`=4, `period`=48'hFFFF_FFFF_FFFF:
  - each bit is held 4 clocks and the parity bit is 0;
  - `busy` lasts 236 clocks.
- A second strobe 20 clocks after the first: the frame is unaffected, `overrun`=1 from the next cycle, and `frames` ends at 1.
- `en`=0 during a strobe: `tx` stays 0, `busy` stays 0, `overrun` stays 0.
- `rst` asserted at bit 30 of a frame: `tx`, `busy`, `overrun` and `frames` go to 0 immediately. After release, the next strobe sends a full frame.
- With `PERIOD_TX_CRC8_EN`, `period`=48'h0000_0000_0001: the CRC field is 8'h07 and `busy` lasts 66 clocks.

Source files
------------

// File: rtl/period_tx_pkg.sv
// rtl/period_tx_pkg.sv - shared types and constants for the period-tag serializer
// Contents: FSM state enum, check-field width, frame length, CRC-8 polynomial
//           and a one-bit CRC-8 step helper.
// Configuration macro: PERIOD_TX_CRC8_EN (8-bit CRC check field instead of parity).
package period_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SYNC,
    ST_DATA,
    ST_CHECK,
    ST_STOP
  } state_e;

  localparam int SYNC_W = 8;

`ifdef PERIOD_TX_CRC8_EN
  localparam int CHECK_W = 8;
`else
  localparam int CHECK_W = 1;
`endif

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // start + sync + data + check + stop
  function automatic int frame_bits(input int period_w);
    return 1 + SYNC_W + period_w + CHECK_W + 1;
  endfunction

  // One MSB-first CRC-8 step: shift left, fold in the polynomial when the
  // bit leaving the register differs from the incoming data bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/period_tx_if.sv
// rtl/period_tx_if.sv - timer-side strobe/period inputs and serial-link status outputs
// Signals: en, period_done, period[PERIOD_W] (timer -> serializer);
//          tx, busy, overrun, frames[16] (serializer -> line/status).
// Modports: master = timer / stimulus side, slave = serializer.
interface period_tx_if #(
  parameter int PERIOD_W = 48
);
  logic                en;
  logic                period_done;
  logic [PERIOD_W-1:0] period;
  logic                tx;
  logic                busy;
  logic                overrun;
  logic [15:0]         frames;

  modport master (
    output en, period_done, period,
    input  tx, busy, overrun, frames
  );

  modport slave (
    input  en, period_done, period,
    output tx, busy, overrun, frames
  );
endinterface

// File: rtl/crc8_serial.sv
// rtl/crc8_serial.sv - bit-serial CRC-8 (poly 0x07, init 0, unreflected, no final XOR)
// Ports: clk, rst (async active-low), clear (sync zero), bit_en (absorb data_bit),
//        data_bit (MSB-first input), crc[8] (current remainder).
module crc8_serial
  import period_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       bit_en,
  input  logic       data_bit,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= 8'h00;
    end else if (bit_en) begin
      crc <= crc8_step(crc, data_bit);
    end
  end

endmodule

// File: rtl/period_tx.sv
// rtl/period_tx.sv - serializes the latched period count as a framed, checked word
// Ports: clk, rst (async active-low), bus (period_tx_if.slave: en, period_done,
//        period in; tx, busy, overrun, frames out).
// Frame (MSB first): start 1, SYNC_WORD, period, check field, stop 0; each bit DIV clocks.
// Configuration macro: PERIOD_TX_CRC8_EN selects a CRC-8 check field (else even parity).
module period_tx
  import period_tx_pkg::*;
#(
  parameter int         PERIOD_W  = 48,
  parameter int         DIV       = 1,
  parameter logic [7:0] SYNC_WORD = 8'hB5
) (
  input logic        clk,
  input logic        rst,
  period_tx_if.slave bus
);

  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_MAX = (PERIOD_W > SYNC_W) ? PERIOD_W : SYNC_W;
  localparam int IDX_W   = $clog2(IDX_MAX);
  localparam int SH_W    = SYNC_W + PERIOD_W;

  state_e           state_q;
  state_e           state_n;
  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] last_idx;
  logic [SH_W-1:0]  sh_q;
  logic             overrun_q;
  logic [15:0]      frames_q;
  logic             accept;
  logic             bit_end;
  logic             field_end;
  logic             check_bit;
  logic             tx_c;
  logic             busy_c;

  assign accept    = (state_q == ST_IDLE) && bus.period_done && bus.en;
  assign bit_end   = (div_q == DIV_W'(DIV - 1));
  assign field_end = bit_end && (idx_q == last_idx);

  // Index of the last bit in the field owned by the current state.
  always_comb begin
    last_idx = '0;
    case (state_q)
      ST_SYNC:  last_idx = IDX_W'(SYNC_W - 1);
      ST_DATA:  last_idx = IDX_W'(PERIOD_W - 1);
      ST_CHECK: last_idx = IDX_W'(CHECK_W - 1);
      default:  last_idx = '0;
    endcase
  end

`ifdef PERIOD_TX_CRC8_EN
  logic [7:0] crc;

  // Remainder accumulates as each data bit finishes on the line.
  crc8_serial u_crc (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .bit_en   ((state_q == ST_DATA) && bit_end),
    .data_bit (sh_q[SH_W-1]),
    .crc      (crc)
  );

  assign check_bit = crc[3'(CHECK_W - 1) - idx_q[2:0]];
`else
  logic par_q;

  // Running XOR of the data bits as they are shifted out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= 1'b0;
    end else if ((state_q == ST_DATA) && bit_end) begin
      par_q <= par_q ^ sh_q[SH_W-1];
    end
  end

  assign check_bit = par_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (bus.period_done && bus.en) state_n = ST_START;
      ST_START: if (field_end) state_n = ST_SYNC;
      ST_SYNC:  if (field_end) state_n = ST_DATA;
      ST_DATA:  if (field_end) state_n = ST_CHECK;
      ST_CHECK: if (field_end) state_n = ST_STOP;
      ST_STOP:  if (field_end) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Output logic: Moore outputs from the registered state and shifter
  always_comb begin
    tx_c   = 1'b0;
    busy_c = 1'b1;
    case (state_q)
      ST_IDLE:          busy_c = 1'b0;
      ST_START:         tx_c   = 1'b1;
      ST_SYNC, ST_DATA: tx_c   = sh_q[SH_W-1];
      ST_CHECK:         tx_c   = check_bit;
      ST_STOP:          tx_c   = 1'b0;
      default:          busy_c = 1'b0;
    endcase
  end

  // Bit timing, shifter and status counters.
  // The shifter holds {SYNC_WORD, period}; it is only loaded from IDLE, so a
  // strobe arriving mid-frame cannot disturb the word being sent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      overrun_q <= 1'b0;
      frames_q  <= 16'd0;
    end else begin
      if (state_q == ST_IDLE) begin
        div_q <= '0;
        idx_q <= '0;
        if (accept) begin
          sh_q <= {SYNC_WORD, bus.period};
        end
      end else begin
        if (bit_end) begin
          div_q <= '0;
          idx_q <= field_end ? '0 : idx_q + IDX_W'(1);
          if ((state_q == ST_SYNC) || (state_q == ST_DATA)) begin
            sh_q <= {sh_q[SH_W-2:0], 1'b0};
          end
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
        // Any strobe outside IDLE, including the last stop-bit cycle, is lost.
        if (bus.period_done) begin
          overrun_q <= 1'b1;
        end
        if ((state_q == ST_STOP) && field_end) begin
          frames_q <= frames_q + 16'd1;
        end
      end
    end
  end

  assign bus.tx      = tx_c;
  assign bus.busy    = busy_c;
  assign bus.overrun = overrun_q;
  assign bus.frames  = frames_q;

endmodule

// File: tb/tb_period_tx.sv
// tb/tb_period_tx.sv - self-checking bench for period_tx (DIV=1 and DIV=4 instances)
module tb_period_tx;

`ifdef PERIOD_TX_CRC8_EN
  localparam int CW = 8;
  localparam int FB = 66;
`else
  localparam int CW = 1;
  localparam int FB = 59;
`endif

  typedef struct {
    logic [47:0] period;
    logic        en;
    logic        exp_par;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_frames1;
  int   exp_frames4;
  logic exp_q[$];
  vec_t vecs[5];

  period_tx_if #(.PERIOD_W(48)) if_d1 ();
  period_tx_if #(.PERIOD_W(48)) if_d4 ();

  period_tx #(.PERIOD_W(48), .DIV(1), .SYNC_WORD(8'hB5)) u_d1 (
    .clk (clk),
    .rst (rst),
    .bus (if_d1.slave)
  );

  period_tx #(.PERIOD_W(48), .DIV(4), .SYNC_WORD(8'hB5)) u_d4 (
    .clk (clk),
    .rst (rst),
    .bus (if_d4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_crc(input logic [47:0] p);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 47; i >= 0; i--) begin
      fb = c[7] ^ p[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic push_frame(input logic [47:0] p, input logic exp_par);
    logic [7:0] sw;
    logic [7:0] ck;
    sw = 8'hB5;
`ifdef PERIOD_TX_CRC8_EN
    ck = (p == 48'h1) ? 8'h07 : tb_crc(p);
`else
    ck = {7'd0, exp_par};
`endif
    exp_q.push_back(1'b1);
    for (int i = 7; i >= 0; i--) exp_q.push_back(sw[i]);
    for (int i = 47; i >= 0; i--) exp_q.push_back(p[i]);
    for (int i = CW - 1; i >= 0; i--) exp_q.push_back(ck[i]);
    exp_q.push_back(1'b0);
  endtask

  task automatic set_in(input int sel, input logic pd, input logic [47:0] p, input logic e);
    if (sel == 1) begin
      if_d1.period_done = pd;
      if_d1.period      = p;
      if_d1.en          = e;
    end else begin
      if_d4.period_done = pd;
      if_d4.period      = p;
      if_d4.en          = e;
    end
  endtask

  function automatic logic get_tx(input int sel);
    return (sel == 1) ? if_d1.tx : if_d4.tx;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 1) ? if_d1.busy : if_d4.busy;
  endfunction

  function automatic logic [15:0] get_frames(input int sel);
    return (sel == 1) ? if_d1.frames : if_d4.frames;
  endfunction

  // One-clock strobe; the DUT samples it at the second posedge here (edge T).
  task automatic strobe(input int sel, input logic [47:0] p, input logic e, input logic exp_par);
    @(posedge clk);
    #1;
    set_in(sel, 1'b1, p, e);
    if (e) push_frame(p, exp_par);
    @(posedge clk);
    #1;
    set_in(sel, 1'b0, p, 1'b1);
  endtask

  // Pops the scoreboard one bit per DIV clocks, then checks busy drop and frame count.
  task automatic check_frame(input int sel, input int div);
    logic b;
    int   n;
    n = 0;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      for (int k = 0; k < div; k++) begin
        @(negedge clk);
        chk($sformatf("tx_bit%0d_clk%0d", n, k), 64'(get_tx(sel)), 64'(b));
        chk($sformatf("busy_bit%0d_clk%0d", n, k), 64'(get_busy(sel)), 64'd1);
      end
      n++;
    end
    @(negedge clk);
    chk("busy_fall", 64'(get_busy(sel)), 64'd0);
    if (sel == 1) exp_frames1++;
    else exp_frames4++;
    chk("frames_after", 64'(get_frames(sel)),
        64'((sel == 1) ? exp_frames1 : exp_frames4));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_frames1 = 0;
    exp_frames4 = 0;
    rst         = 1'b0;
    set_in(1, 1'b0, 48'h0, 1'b1);
    set_in(4, 1'b0, 48'h0, 1'b1);

    vecs[0] = '{period: 48'h0000_0000_0001, en: 1'b1, exp_par: 1'b1};
    vecs[1] = '{period: 48'hFFFF_FFFF_FFFF, en: 1'b1, exp_par: 1'b0};
    vecs[2] = '{period: 48'hA5A5_0F0F_1234, en: 1'b1, exp_par: 1'b1};
    vecs[3] = '{period: 48'h0000_0000_0000, en: 1'b1, exp_par: 1'b0};
    vecs[4] = '{period: 48'h8000_0000_0001, en: 1'b0, exp_par: 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx", 64'(if_d1.tx), 64'd0);
    chk("rst_busy", 64'(if_d1.busy), 64'd0);
    chk("rst_overrun", 64'(if_d1.overrun), 64'd0);
    chk("rst_frames", 64'(if_d1.frames), 64'd0);
    chk("rst_busy4", 64'(if_d4.busy), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames on the DIV=1 instance
    for (int v = 0; v < 5; v++) begin
      strobe(1, vecs[v].period, vecs[v].en, vecs[v].exp_par);
      if (vecs[v].en) begin
        check_frame(1, 1);
      end else begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("dis_tx", 64'(if_d1.tx), 64'd0);
          chk("dis_busy", 64'(if_d1.busy), 64'd0);
          chk("dis_overrun", 64'(if_d1.overrun), 64'd0);
        end
      end
      repeat (2) @(negedge clk);
    end

    // DIV=4: each bit held four clocks, busy FB*4 clocks
    strobe(4, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0);
    check_frame(4, 4);
    chk("d4_overrun", 64'(if_d4.overrun), 64'd0);

    // Second strobe 20 clocks into a frame
    strobe(1, 48'hFFFF_0000_0001, 1'b1, 1'b1);
    fork
      check_frame(1, 1);
      begin
        repeat (19) @(posedge clk);
        #1;
        chk("ovr_before", 64'(if_d1.overrun), 64'd0);
        if_d1.period_done = 1'b1;
        if_d1.period      = 48'h0000_DEAD_BEEF;
        @(posedge clk);
        #1;
        if_d1.period_done = 1'b0;
        @(negedge clk);
        chk("ovr_after", 64'(if_d1.overrun), 64'd1);
      end
    join
    chk("ovr_sticky", 64'(if_d1.overrun), 64'd1);
    repeat (3) @(negedge clk);
    chk("ovr_no_frame", 64'(if_d1.busy), 64'd0);

    // Reset asserted at bit 30 of a frame
    strobe(1, 48'h1234_5678_9ABC, 1'b1, 1'b0);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      chk($sformatf("pre_rst_bit%0d", n), 64'(if_d1.tx), 64'(exp_q.pop_front()));
    end
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", 64'(if_d1.tx), 64'd0);
    chk("mid_rst_busy", 64'(if_d1.busy), 64'd0);
    chk("mid_rst_overrun", 64'(if_d1.overrun), 64'd0);
    chk("mid_rst_frames", 64'(if_d1.frames), 64'd0);
    exp_q.delete();
    exp_frames1 = 0;
    exp_frames4 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    strobe(1, 48'h1234_5678_9ABC, 1'b1, 1'b0);
    check_frame(1, 1);

    // Strobe in the final stop-bit cycle counts as an overrun
    chk("stop_ovr_before", 64'(if_d1.overrun), 64'd0);
    strobe(1, 48'h0000_0000_0003, 1'b1, 1'b0);
    fork
      check_frame(1, 1);
      begin
        repeat (FB - 1) @(posedge clk);
        #1;
        if_d1.period_done = 1'b1;
        if_d1.period      = 48'h0000_0000_00FF;
        @(posedge clk);
        #1;
        if_d1.period_done = 1'b0;
      end
    join
    chk("stop_ovr_set", 64'(if_d1.overrun), 64'd1);
    @(negedge clk);
    chk("stop_ovr_idle", 64'(if_d1.busy), 64'd0);
    chk("stop_ovr_tx", 64'(if_d1.tx), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
